fastdiv_q88_bcd_fmt: RTL and testbench

Downstream formatting stage for the fastdiv quotient.
- Consumes the 16-bit unsigned Q8.8 quotient word (upper byte integer, lower byte fraction) that fastdiv drives on xyout.
- Converts it sequentially into packed BCD digits for the display/readout path: 3 integer digits plus FRAC_DIGITS fraction digits.
- Uses a valid/ready handshake on both sides so the display side can stall it.

---
 rtl/fastdiv_q88_bcd_fmt.sv | 158 +++++++++++++++
 tb/tb_fastdiv_q88_bcd_fmt.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fastdiv_q88_bcd_fmt.sv
// rtl/fastdiv_q88_bcd_fmt.sv - Q8.8 quotient to packed BCD formatter (double-dabble + x10 fraction)
// Optional rounding via FASTDIV_BCD_ROUND_EN (guard digit + ROUND state).
module fastdiv_q88_bcd_fmt #(
  parameter int FRAC_DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [11:0]              out_int_bcd,
  output logic [4*FRAC_DIGITS-1:0] out_frac_bcd,
  output logic                     busy
);

  localparam int FW = 4 * FRAC_DIGITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INT   = 3'd1;
  localparam logic [2:0] S_FRAC  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef FASTDIV_BCD_ROUND_EN
  localparam logic [2:0] S_ROUND = 3'd3;
  // One extra iteration produces the guard digit.
  localparam logic [3:0] FRAC_LAST = 4'(FRAC_DIGITS);
`else
  localparam logic [3:0] FRAC_LAST = 4'(FRAC_DIGITS - 1);
`endif

  logic [2:0]    state;
  logic [19:0]   dd;
  logic [7:0]    frac;
  logic [3:0]    cnt;
  logic [FW-1:0] digits;
  logic [11:0]   int_q;
  logic [FW-1:0] frac_q;

  logic [19:0]   dd_adj;
  logic [19:0]   dd_next;
  logic [11:0]   prod;
  logic [FW-1:0] digits_next;

  // Double-dabble: correct BCD nibbles >= 5 before the shift.
  always_comb begin
    dd_adj = dd;
    for (int k = 0; k < 3; k++) begin
      if (dd[8+4*k +: 4] >= 4'd5) begin
        dd_adj[8+4*k +: 4] = dd[8+4*k +: 4] + 4'd3;
      end
    end
    dd_next = {dd_adj[18:0], 1'b0};
  end

  assign prod        = {4'd0, frac} * 12'd10;
  assign digits_next = FW'({digits, prod[11:8]});

`ifdef FASTDIV_BCD_ROUND_EN
  logic [3:0]             guard;
  logic [FW+11:0]         rnd_val;
  logic                   rnd_c;

  // Increment the whole int+frac BCD string by one LSD with decimal carry.
  always_comb begin
    rnd_val = {dd[19:8], digits};
    rnd_c   = (guard >= 4'd5);
    for (int i = 0; i < FRAC_DIGITS + 3; i++) begin
      if (rnd_c) begin
        if (rnd_val[4*i +: 4] == 4'd9) begin
          rnd_val[4*i +: 4] = 4'd0;
        end else begin
          rnd_val[4*i +: 4] = rnd_val[4*i +: 4] + 4'd1;
          rnd_c = 1'b0;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      dd     <= '0;
      frac   <= '0;
      cnt    <= '0;
      digits <= '0;
      int_q  <= '0;
      frac_q <= '0;
`ifdef FASTDIV_BCD_ROUND_EN
      guard  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dd     <= {12'd0, in_data[15:8]};
            frac   <= in_data[7:0];
            cnt    <= '0;
            digits <= '0;
`ifdef FASTDIV_BCD_ROUND_EN
            guard  <= '0;
`endif
            state  <= S_INT;
          end
        end
        S_INT: begin
          dd <= dd_next;
          if (cnt == 4'd7) begin
            cnt   <= '0;
            state <= S_FRAC;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_FRAC: begin
          frac <= prod[7:0];
          cnt  <= cnt + 4'd1;
`ifdef FASTDIV_BCD_ROUND_EN
          if (cnt == FRAC_LAST) begin
            guard <= prod[11:8];
            state <= S_ROUND;
          end else begin
            digits <= digits_next;
          end
`else
          digits <= digits_next;
          if (cnt == FRAC_LAST) begin
            int_q  <= dd[19:8];
            frac_q <= digits_next;
            state  <= S_DONE;
          end
`endif
        end
`ifdef FASTDIV_BCD_ROUND_EN
        S_ROUND: begin
          int_q  <= rnd_val[FW+11:FW];
          frac_q <= rnd_val[FW-1:0];
          state  <= S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign out_valid    = (state == S_DONE);
  assign out_int_bcd  = int_q;
  assign out_frac_bcd = frac_q;

endmodule

// File: tb/tb_fastdiv_q88_bcd_fmt.sv
// tb/tb_fastdiv_q88_bcd_fmt.sv - self-checking bench for fastdiv_q88_bcd_fmt (default and FRAC_DIGITS=1)
module tb_fastdiv_q88_bcd_fmt;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [11:0] out_int_bcd;
  logic [11:0] out_frac_bcd;

  logic        b_in_valid, b_out_ready;
  logic [15:0] b_in_data;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [11:0] b_out_int_bcd;
  logic [3:0]  b_out_frac_bcd;

  int checks = 0;
  int errors = 0;

`ifdef FASTDIV_BCD_ROUND_EN
  localparam int LAT_EXTRA = 10;
`else
  localparam int LAT_EXTRA = 8;
`endif

  fastdiv_q88_bcd_fmt #(.FRAC_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_int_bcd(out_int_bcd),
    .out_frac_bcd(out_frac_bcd), .busy(busy)
  );

  fastdiv_q88_bcd_fmt #(.FRAC_DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_int_bcd(b_out_int_bcd),
    .out_frac_bcd(b_out_frac_bcd), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input longint v, input int n);
    logic [31:0] r;
    longint t;
    r = '0;
    t = v;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal value scaled by 10^fd, truncated or rounded from the exact quotient.
  task automatic model(input logic [15:0] d, input int fd, output logic [31:0] ib, output logic [31:0] fb);
    longint p, r, q;
    p = 1;
    for (int i = 0; i < fd; i++) p = p * 10;
`ifdef FASTDIV_BCD_ROUND_EN
    q = (longint'(d) * p * 10) >> 8;
    r = q / 10 + ((q % 10) >= 5 ? 1 : 0);
`else
    q = 0;
    r = (longint'(d) * p) >> 8;
`endif
    ib = to_bcd(r / p + q * 0, 3);
    fb = to_bcd(r % p, fd);
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, exp_lat);
  endtask

  task automatic check_result(input logic [15:0] d);
    logic [31:0] ib, fb;
    model(d, 3, ib, fb);
    chk($sformatf("int_%04h", d), {20'd0, out_int_bcd}, ib);
    chk($sformatf("frac_%04h", d), {20'd0, out_frac_bcd}, fb);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_cleared", {31'd0, out_valid}, 32'd0);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic convert(input logic [15:0] d);
    send(d);
    wait_done(LAT_EXTRA + 3);
    check_result(d);
    release_out();
  endtask

  task automatic convert_b(input logic [15:0] d);
    logic [31:0] ib, fb;
    int n;
    model(d, 1, ib, fb);
    @(negedge clk);
    b_in_data  = d;
    b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_latency", n, LAT_EXTRA + 1);
    chk($sformatf("b_int_%04h", d), {20'd0, b_out_int_bcd}, ib);
    chk($sformatf("b_frac_%04h", d), {28'd0, b_out_frac_bcd}, fb);
    @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    b_out_ready = 1'b0;
    chk("b_valid_cleared", {31'd0, b_out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ib1, fb1;
    logic [15:0] w;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_int", {20'd0, out_int_bcd}, 32'd0);
    chk("rst_frac", {20'd0, out_frac_bcd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values
    convert(16'h2000);
    convert(16'h0280);
    convert(16'h0540);
    convert(16'h1B00);
    convert(16'h2AAA);
    convert(16'h0000);
    convert(16'hFFFF);
    convert(16'h0001);

    // Backpressure with a competing input word
    send(16'h0540);
    chk("busy_mid", {31'd0, busy}, 32'd1);
    wait_done(LAT_EXTRA + 3);
    model(16'h0540, 3, ib1, fb1);
    @(negedge clk);
    in_data  = 16'h2AAA;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_int", {20'd0, out_int_bcd}, ib1);
      chk("bp_frac", {20'd0, out_frac_bcd}, fb1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_new_taken", {31'd0, busy}, 32'd1);
    wait_done(LAT_EXTRA + 3);
    check_result(16'h2AAA);
    release_out();

    // Reset during the 4th INT cycle, after a nonzero result is held
    convert(16'h1B00);
    send(16'h1234);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_int", {20'd0, out_int_bcd}, 32'd0);
    chk("mid_rst_frac", {20'd0, out_frac_bcd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    convert(16'h2000);

    // Randomized words
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      convert(w);
    end

    // FRAC_DIGITS=1 instance
    convert_b(16'h00FF);
    convert_b(16'h0280);
    for (int i = 0; i < 5; i++) begin
      w = 16'($urandom);
      convert_b(w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
